// File: rtl/pio_color_fader_pkg.sv
// pio_color_fader_pkg
// Definitions shared by the colour fader and its prescaler:
//   - state_e       : fader FSM states
//   - CH_R/CH_G/CH_B: channel index inside a packed {R,G,B} colour,
//                     which is also the pio_chipselect bit for that channel
//   - PIO_DATA_ADDR : Avalon word address of the PIO data register
//   - PRESC_W       : prescaler width, wide enough for STEP_DIV up to 65535
package pio_color_fader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    STEP = 3'd2,
    WR_R = 3'd3,
    WR_G = 3'd4,
    WR_B = 3'd5,
    DONE = 3'd6
  } state_e;

  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  localparam int PRESC_W = 16;

endpackage

// File: rtl/fader_prescaler.sv
// fader_prescaler
// Loadable down-counter that paces the fade steps. It counts down by one on
// each dec_i cycle, stops at zero, and reports zero on zero_o.
// Ports:
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (count -> 0)
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : reload value
//   dec_i      : decrement request
//   zero_o     : count is zero
module fader_prescaler
  import pio_color_fader_pkg::*;
#(
  parameter int CNT_W = PRESC_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pio_color_fader.sv
// pio_color_fader
// Fades an RGB colour held in three Avalon PIO peripherals toward a requested
// target, one unit per channel every STEP_DIV+4 cycles. Each step is followed
// by a write pass (red, green, blue PIO on consecutive cycles). A request equal
// to the current colour produces a single immediate refresh pass.
// Optional feature: define PIO_COLOR_FADER_RETARGET_EN to allow a new target
// to be accepted while waiting between steps (the fade re-aims from the
// current colour).
// Parameters: STEP_DIV (1..65535) cycles between steps, CH_W channel width.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   req_valid/ready  : target colour handshake, req_color = {R,G,B}
//   busy             : fade or write pass in progress
//   done             : one-cycle pulse when the target is reached
//   cur_color        : colour last written to the PIOs, {R,G,B}
//   pio_chipselect   : one-hot {red, green, blue} PIO select
//   pio_write_n      : active-low write strobe
//   pio_address      : always the data register
//   pio_writedata    : channel value, zero-extended
module pio_color_fader
  import pio_color_fader_pkg::*;
#(
  parameter int STEP_DIV = 1024,
  parameter int CH_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3*CH_W-1:0] req_color,
  output logic              busy,
  output logic              done,
  output logic [3*CH_W-1:0] cur_color,
  output logic [2:0]        pio_chipselect,
  output logic              pio_write_n,
  output logic [1:0]        pio_address,
  output logic [31:0]       pio_writedata
);

  localparam logic [PRESC_W-1:0] PRESC_RELOAD = PRESC_W'(STEP_DIV - 1);

  state_e            state_q, state_d;
  logic [3*CH_W-1:0] target_q, target_d;
  logic [3*CH_W-1:0] cur_q, cur_d;
  logic              accept;
  logic              ps_load, ps_dec, ps_zero;

  // Move one unit toward the target without ever wrapping.
  function automatic logic [CH_W-1:0] step_ch(input logic [CH_W-1:0] cur,
                                              input logic [CH_W-1:0] tgt);
    if (cur < tgt)      return cur + 1'b1;
    else if (cur > tgt) return cur - 1'b1;
    else                return cur;
  endfunction

  function automatic logic [CH_W-1:0] chan(input logic [3*CH_W-1:0] color,
                                           input int                idx);
    return color[idx*CH_W +: CH_W];
  endfunction

`ifdef PIO_COLOR_FADER_RETARGET_EN
  assign req_ready = (state_q == IDLE) || (state_q == WAIT);
`else
  assign req_ready = (state_q == IDLE);
`endif

  assign accept = req_valid && req_ready;

  fader_prescaler #(
    .CNT_W (PRESC_W)
  ) u_presc (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (ps_load),
    .load_val_i (PRESC_RELOAD),
    .dec_i      (ps_dec),
    .zero_o     (ps_zero)
  );

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cur_d    = cur_q;
    ps_load  = 1'b0;
    ps_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = req_color;
          if (req_color != cur_q) begin
            state_d = WAIT;
            ps_load = 1'b1;
          end else begin
            state_d = WR_R;
          end
        end
      end
      WAIT: begin
`ifdef PIO_COLOR_FADER_RETARGET_EN
        // A new target wins over an expiring prescaler.
        if (accept) begin
          target_d = req_color;
          ps_load  = 1'b1;
        end else
`endif
        if (ps_zero) begin
          state_d = STEP;
        end else begin
          ps_dec = 1'b1;
        end
      end
      STEP: begin
        for (int i = 0; i < 3; i++) begin
          cur_d[i*CH_W +: CH_W] = step_ch(chan(cur_q, i), chan(target_q, i));
        end
        state_d = WR_R;
      end
      WR_R: state_d = WR_G;
      WR_G: state_d = WR_B;
      WR_B: begin
        if (cur_q == target_q) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          ps_load = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= '0;
      cur_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cur_q    <= cur_d;
    end
  end

  always_comb begin
    pio_chipselect = 3'b000;
    pio_write_n    = 1'b1;
    pio_writedata  = 32'd0;
    case (state_q)
      WR_R: begin
        pio_chipselect[CH_R] = 1'b1;
        pio_write_n          = 1'b0;
        pio_writedata        = 32'(chan(cur_q, CH_R));
      end
      WR_G: begin
        pio_chipselect[CH_G] = 1'b1;
        pio_write_n          = 1'b0;
        pio_writedata        = 32'(chan(cur_q, CH_G));
      end
      WR_B: begin
        pio_chipselect[CH_B] = 1'b1;
        pio_write_n          = 1'b0;
        pio_writedata        = 32'(chan(cur_q, CH_B));
      end
      default: ;
    endcase
  end

  assign pio_address = PIO_DATA_ADDR;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign cur_color   = cur_q;

endmodule

// File: tb/tb_pio_color_fader.sv
// tb_pio_color_fader
// Directed bench for pio_color_fader with STEP_DIV=4, CH_W=8. Inputs change
// on/just after the rising edge, outputs are sampled on the falling edge.
// The retarget scenario follows PIO_COLOR_FADER_RETARGET_EN when defined.
module tb_pio_color_fader;

  localparam int STEP_DIV = 4;
  localparam int CH_W     = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_color = 24'h0;
  logic        busy, done;
  logic [23:0] cur_color;
  logic [2:0]  pio_chipselect;
  logic        pio_write_n;
  logic [1:0]  pio_address;
  logic [31:0] pio_writedata;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  pio_color_fader #(.STEP_DIV(STEP_DIV), .CH_W(CH_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_color      (req_color),
    .busy           (busy),
    .done           (done),
    .cur_color      (cur_color),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_address    (pio_address),
    .pio_writedata  (pio_writedata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Present a request at a falling edge, hold it over one rising edge.
  task automatic send_req(input logic [23:0] color);
    req_color = color;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Capture one write pass. gap = falling edges until WR_R (-1 on timeout);
  // ok clears on any malformed strobe or non-idle bus between writes.
  task automatic capture_pass(input int limit, output int gap,
                              output logic [7:0] r, output logic [7:0] g,
                              output logic [7:0] b, output bit ok);
    gap = -1; ok = 1'b1; r = 8'h0; g = 8'h0; b = 8'h0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (pio_chipselect !== 3'b000) begin gap = i; break; end
      if (pio_write_n !== 1'b1 || pio_writedata !== 32'd0 || pio_address !== 2'd0) ok = 1'b0;
    end
    if (gap < 0) begin ok = 1'b0; return; end
    if (pio_chipselect !== 3'b100 || pio_write_n !== 1'b0 || pio_address !== 2'd0 || pio_writedata[31:8] !== 24'd0) ok = 1'b0;
    r = pio_writedata[7:0];
    @(negedge clk);
    if (pio_chipselect !== 3'b010 || pio_write_n !== 1'b0 || pio_address !== 2'd0 || pio_writedata[31:8] !== 24'd0) ok = 1'b0;
    g = pio_writedata[7:0];
    @(negedge clk);
    if (pio_chipselect !== 3'b001 || pio_write_n !== 1'b0 || pio_address !== 2'd0 || pio_writedata[31:8] !== 24'd0) ok = 1'b0;
    b = pio_writedata[7:0];
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    bit cs_seen;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset busy/done: got %b/%b want 0/0", busy, done); end
    n_cmp++; if (pio_chipselect !== 3'b000 || pio_write_n !== 1'b1 || pio_writedata !== 32'd0) begin n_bad++; $display("FAIL reset pio: cs=%b wn=%b wd=%h want 000/1/0", pio_chipselect, pio_write_n, pio_writedata); end
    cs_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (pio_chipselect !== 3'b000) cs_seen = 1'b1;
    end
    n_cmp++; if (cs_seen !== 1'b0) begin n_bad++; $display("FAIL idle chipselect: got seen=%b want 0", cs_seen); end
    n_cmp++; if (cur_color !== 24'h000000) begin n_bad++; $display("FAIL idle cur_color: got %h want 000000", cur_color); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL idle req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_fade_up;
    logic [23:0] exp_c [3];
    int gap; logic [7:0] r, g, b; bit ok;
    exp_c[0] = 24'h010101; exp_c[1] = 24'h020201; exp_c[2] = 24'h030201;
    done_cnt = 0;
    send_req(24'h030201);
    for (int p = 0; p < 3; p++) begin
      capture_pass(20, gap, r, g, b, ok);
      n_cmp++; if (gap !== 6) begin n_bad++; $display("FAIL fade_up gap pass%0d: got %0d want 6", p, gap); end
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL fade_up strobes pass%0d: got ok=%b want 1", p, ok); end
      n_cmp++; if ({r, g, b} !== exp_c[p]) begin n_bad++; $display("FAIL fade_up data pass%0d: got %h want %h", p, {r, g, b}, exp_c[p]); end
      n_cmp++; if (cur_color !== exp_c[p]) begin n_bad++; $display("FAIL fade_up cur_color pass%0d: got %h want %h", p, cur_color, exp_c[p]); end
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL fade_up done state: got done=%b busy=%b want 1/1", done, busy); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL fade_up idle: got done=%b busy=%b rdy=%b want 0/0/1", done, busy, req_ready); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL fade_up done count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_refresh;
    int gap; logic [7:0] r, g, b; bit ok;
    done_cnt = 0;
    send_req(24'h030201);
    capture_pass(20, gap, r, g, b, ok);
    n_cmp++; if (gap !== 1) begin n_bad++; $display("FAIL refresh gap: got %0d want 1", gap); end
    n_cmp++; if (ok !== 1'b1 || {r, g, b} !== 24'h030201) begin n_bad++; $display("FAIL refresh data: got ok=%b %h want 1 030201", ok, {r, g, b}); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL refresh done: got %b want 1", done); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || done_cnt !== 1) begin n_bad++; $display("FAIL refresh end: got busy=%b dones=%0d want 0/1", busy, done_cnt); end
  endtask

  task automatic test_fade_down;
    int gap; logic [7:0] r, g, b; bit ok;
    logic [23:0] want;
    send_req(24'h050505);
    wait_done(200, ok);
    n_cmp++; if (ok !== 1'b1 || cur_color !== 24'h050505) begin n_bad++; $display("FAIL down setup: got ok=%b %h want 1 050505", ok, cur_color); end
    @(negedge clk);
    done_cnt = 0;
    send_req(24'h020505);
    for (int p = 0; p < 3; p++) begin
      want = {8'(4 - p), 8'h05, 8'h05};
      capture_pass(20, gap, r, g, b, ok);
      n_cmp++; if (gap !== 6 || ok !== 1'b1) begin n_bad++; $display("FAIL down pass%0d: got gap=%0d ok=%b want 6/1", p, gap, ok); end
      n_cmp++; if ({r, g, b} !== want) begin n_bad++; $display("FAIL down data pass%0d: got %h want %h", p, {r, g, b}, want); end
    end
    wait_done(3, ok);
    @(negedge clk);
    n_cmp++; if (ok !== 1'b1 || busy !== 1'b0 || cur_color !== 24'h020505 || done_cnt !== 1) begin n_bad++; $display("FAIL down end: got ok=%b busy=%b cur=%h dones=%0d want 1/0/020505/1", ok, busy, cur_color, done_cnt); end
  endtask

  task automatic test_retarget;
    int gap; logic [7:0] r, g, b; bit ok;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    done_cnt = 0;
    send_req(24'h0A0000);
    capture_pass(20, gap, r, g, b, ok);
    n_cmp++; if (r !== 8'd1 || ok !== 1'b1) begin n_bad++; $display("FAIL retarget pass1: got r=%0d ok=%b want 1/1", r, ok); end
    capture_pass(20, gap, r, g, b, ok);
    n_cmp++; if (r !== 8'd2 || ok !== 1'b1) begin n_bad++; $display("FAIL retarget pass2: got r=%0d ok=%b want 2/1", r, ok); end
    @(negedge clk);
`ifdef PIO_COLOR_FADER_RETARGET_EN
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL retarget ready in wait: got %b want 1", req_ready); end
    send_req(24'h000000);
    capture_pass(20, gap, r, g, b, ok);
    n_cmp++; if (gap !== 6 || r !== 8'd1 || ok !== 1'b1) begin n_bad++; $display("FAIL retarget back1: got gap=%0d r=%0d ok=%b want 6/1/1", gap, r, ok); end
    capture_pass(20, gap, r, g, b, ok);
    n_cmp++; if (gap !== 6 || r !== 8'd0 || ok !== 1'b1) begin n_bad++; $display("FAIL retarget back0: got gap=%0d r=%0d ok=%b want 6/0/1", gap, r, ok); end
    wait_done(3, ok);
    @(negedge clk);
    n_cmp++; if (ok !== 1'b1 || cur_color !== 24'h0 || busy !== 1'b0 || done_cnt !== 1) begin n_bad++; $display("FAIL retarget end: got ok=%b cur=%h busy=%b dones=%0d want 1/000000/0/1", ok, cur_color, busy, done_cnt); end
`else
    begin
      bit seq_ok;
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL hold ready in wait: got %b want 0", req_ready); end
      req_color = 24'h000000;
      req_valid = 1'b1;
      seq_ok = 1'b1;
      for (int p = 3; p <= 10; p++) begin
        capture_pass(20, gap, r, g, b, ok);
        if (r !== 8'(p) || ok !== 1'b1 || gap !== ((p == 3) ? 5 : 6)) seq_ok = 1'b0;
      end
      n_cmp++; if (seq_ok !== 1'b1) begin n_bad++; $display("FAIL hold fade continues: got seq_ok=%b want 1", seq_ok); end
      wait_done(3, ok);
      n_cmp++; if (ok !== 1'b1 || cur_color !== 24'h0A0000) begin n_bad++; $display("FAIL hold first done: got ok=%b cur=%h want 1 0A0000", ok, cur_color); end
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL hold idle: got rdy=%b busy=%b want 1/0", req_ready, busy); end
      @(posedge clk);
      #1 req_valid = 1'b0;
      capture_pass(20, gap, r, g, b, ok);
      n_cmp++; if (gap !== 6 || r !== 8'd9 || ok !== 1'b1) begin n_bad++; $display("FAIL hold second fade: got gap=%0d r=%0d ok=%b want 6/9/1", gap, r, ok); end
      wait_done(200, ok);
      @(negedge clk);
      n_cmp++; if (ok !== 1'b1 || cur_color !== 24'h0 || done_cnt !== 2) begin n_bad++; $display("FAIL hold end: got ok=%b cur=%h dones=%0d want 1/000000/2", ok, cur_color, done_cnt); end
    end
`endif
  endtask

  task automatic test_reset_mid;
    int gap; logic [7:0] r, g, b; bit ok; bit found;
    send_req(24'h030303);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pio_chipselect === 3'b010) begin found = 1'b1; break; end
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL midreset reach WR_G: got %b want 1", found); end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (pio_chipselect !== 3'b000 || pio_write_n !== 1'b1 || pio_writedata !== 32'd0) begin n_bad++; $display("FAIL midreset pio: cs=%b wn=%b wd=%h want 000/1/0", pio_chipselect, pio_write_n, pio_writedata); end
    n_cmp++; if (cur_color !== 24'h0 || busy !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL midreset state: cur=%h busy=%b rdy=%b want 000000/0/1", cur_color, busy, req_ready); end
    send_req(24'h010101);
    capture_pass(20, gap, r, g, b, ok);
    n_cmp++; if (gap !== 6 || ok !== 1'b1 || {r, g, b} !== 24'h010101) begin n_bad++; $display("FAIL midreset refade: got gap=%0d ok=%b %h want 6/1/010101", gap, ok, {r, g, b}); end
    wait_done(3, ok);
    n_cmp++; if (ok !== 1'b1 || cur_color !== 24'h010101) begin n_bad++; $display("FAIL midreset done: got ok=%b cur=%h want 1 010101", ok, cur_color); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fade_up();
    test_refresh();
    test_fade_down();
    test_retarget();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
